dest_reg_select_pipe: RTL and testbench
=======================================

// Module: dest_reg_select_pipe
// PURPOSE
//  Parametrised N:1 destination-register select feeding a DEPTH-stage delay line with per-stage valid.
//  Carries the write-register address of each instruction (rt/rd/$31 pick) from ID through EX/MEM/WB.
//  Exposes every stage tap plus a per-stage hazard match against a query address, for forwarding/stall logic.
//  Honours pipeline stall (freeze) and flush (bubble insert at stage 0).
// PARAMETERS
//  WIDTH        5  bits per register address
//  NUM_IN       3  number of selectable address inputs (>=2)
//  DEPTH        3  number of pipeline stages carried (>=1)
//  ZERO_IS_NULL 1  1: address 0 never reports a hazard match ($zero)
// PORTS
//  Clk        in   1                  clock; all state updates on rising edge
//  Rst        in   1                  synchronous reset, active-high
//  in_bus     in   NUM_IN*WIDTH       input k at in_bus[k*WIDTH +: WIDTH]
//  sel        in   SW=max(1,$clog2(NUM_IN))  input select
//  in_valid   in   1                  instruction writes a register
//  stall      in   1                  hold all stages
//  flush      in   1                  insert bubble into stage 0
//  query      in   WIDTH              address checked against pipe
//  tap_addr   out  DEPTH*WIDTH        stage s at tap_addr[s*WIDTH +: WIDTH]
//  tap_valid  out  DEPTH              stage s valid bit
//  match      out  DEPTH              match[s] = stage s hits query
//  any_match  out  1                  OR of match
// BEHAVIOUR
//  Select (comb): sel<NUM_IN -> cand=in_bus[sel]; cand_v=in_valid. sel>=NUM_IN -> cand=0, cand_v=0.
//  Entry: cand_v=0 -> stage 0 loads addr 0 (no stale addresses in invalid stages).
//  Rst=1: every tap_addr=0, tap_valid=0 at next edge; overrides stall/flush; mid-run reset discards all.
//  Priority per edge: Rst > flush (stage 0 only) > stall > advance.
//  Advance (no stall/flush): stage0<=cand/cand_v; stage s<=stage s-1 for s=1..DEPTH-1; stage DEPTH-1 drops out.
//  Latency: stage s shows an input s+1 edges after it is presented, absent stalls.
//  stall=1, flush=0: all stages hold addr and valid.
//  flush=1, stall=0: stage0<=0/invalid; stages 1..DEPTH-1 advance normally.
//  flush=1, stall=1: stage0<=0/invalid; stages 1..DEPTH-1 hold.
//  match[s] = tap_valid[s] & (tap_addr[s]==query) & ~(ZERO_IS_NULL & query==0).
//  match/any_match are comb from registers + query: no added latency, no inputs-to-match path except query.
//  All outputs 0 during and right after reset.
// TESTING  (WIDTH=5 NUM_IN=3 DEPTH=3 ZERO_IS_NULL=1; in0=17 in1=9 in2=31)
//  1 Rst=1 2 cycles, random inputs -> tap_addr=0, tap_valid=0, match=0, any_match=0.
//  2 sel=1,v=1 @c0; sel=0,v=1 @c1; sel=2,v=1 @c2 -> after c2 edge tap0=31 tap1=17 tap2=9, valid=3'b111.
//  3 sel=3,v=1 -> next edge tap0=0, tap_valid[0]=0; pipe otherwise advances.
//  4 Pipe {31,17,9}, stall=1 2 cycles -> taps unchanged both cycles; release -> shift resumes.
//  5 Pipe {31,17,9}, stall=1 flush=1 -> tap0=0/invalid, tap1=17, tap2=9 held;
//    flush only -> tap0=0/invalid, tap1=31, tap2=17.
//  6 Pipe {31,17,9} valid, query=17 -> match=3'b010, any_match=1; query=0 with a valid 0 entry -> match=0.
//  7 Rst mid-stream with stall=1 -> all cleared next edge; new inputs enter normally after.

Source files
------------

// File: rtl/dest_reg_select_pipe.sv
// Destination-register select feeding a DEPTH-stage address/valid delay line.
// Each stage is compared against a query address to drive forwarding and stall decisions.
module dest_reg_select_pipe #(
    parameter int WIDTH        = 5,
    parameter int NUM_IN       = 3,
    parameter int DEPTH        = 3,
    parameter int ZERO_IS_NULL = 1,
    localparam int SW          = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SW-1:0]           sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        query,
    output logic [DEPTH*WIDTH-1:0]  tap_addr,
    output logic [DEPTH-1:0]        tap_valid,
    output logic [DEPTH-1:0]        match,
    output logic                    any_match
);

    logic [WIDTH-1:0] cand;
    logic             cand_v;
    logic [WIDTH-1:0] addr_p [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic             qnull;

    // Select: an out-of-range select behaves like a non-writing instruction
    always_comb begin
        cand   = '0;
        cand_v = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                cand   = in_bus[k*WIDTH +: WIDTH];
                cand_v = in_valid;
            end
        end
    end

    // Stage 0 .. DEPTH-1: invalid entries always carry address 0
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                addr_p[s] <= '0;
            end
            vld_p <= '0;
        end else begin
            if (flush) begin
                addr_p[0] <= '0;
                vld_p[0]  <= 1'b0;
            end else if (!stall) begin
                addr_p[0] <= cand_v ? cand : '0;
                vld_p[0]  <= cand_v;
            end
            if (!stall) begin
                for (int s = 1; s < DEPTH; s++) begin
                    addr_p[s] <= addr_p[s-1];
                    vld_p[s]  <= vld_p[s-1];
                end
            end
        end
    end

    // Hazard compare: purely combinational from stage registers and query
    assign qnull = (ZERO_IS_NULL != 0) && (query == '0);

    for (genvar s = 0; s < DEPTH; s++) begin : g_tap
        assign tap_addr[s*WIDTH +: WIDTH] = addr_p[s];
        assign tap_valid[s]               = vld_p[s];
        assign match[s]                   = vld_p[s] && (addr_p[s] == query) && !qnull;
    end

    assign any_match = |match;

endmodule

// File: tb/tb_dest_reg_select_pipe.sv
// Scoreboard bench for dest_reg_select_pipe (WIDTH=5, NUM_IN=3, DEPTH=3, ZERO_IS_NULL=1).
// A reference pipe model pushes expected stage contents per edge; tests pop and compare.
module tb_dest_reg_select_pipe;

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  vld;
        logic [2:0]  m;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [14:0] in_bus;
    logic [1:0]  sel;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  query;
    logic [14:0] tap_addr;
    logic [2:0]  tap_valid;
    logic [2:0]  match;
    logic        any_match;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t e;

    logic [4:0] m_addr [3];
    logic [2:0] m_vld;

    always #5 Clk = ~Clk;

    dest_reg_select_pipe #(
        .WIDTH(5), .NUM_IN(3), .DEPTH(3), .ZERO_IS_NULL(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .query(query), .tap_addr(tap_addr),
        .tap_valid(tap_valid), .match(match), .any_match(any_match)
    );

    // Drive one cycle of stimulus, advance the reference model and push its expectation.
    task automatic step(input logic r, input logic [1:0] s, input logic v,
                        input logic st, input logic fl);
        logic [4:0] na [3];
        logic [2:0] nv;
        exp_t       x;
        @(negedge Clk);
        Rst = r; sel = s; in_valid = v; stall = st; flush = fl;
        for (int i = 0; i < 3; i++) na[i] = m_addr[i];
        nv = m_vld;
        if (r) begin
            for (int i = 0; i < 3; i++) na[i] = 5'd0;
            nv = 3'b000;
        end else begin
            if (!st) begin
                na[2] = m_addr[1]; nv[2] = m_vld[1];
                na[1] = m_addr[0]; nv[1] = m_vld[0];
            end
            if (fl) begin
                na[0] = 5'd0; nv[0] = 1'b0;
            end else if (!st) begin
                if (s < 2'd3 && v) begin
                    na[0] = in_bus[int'(s)*5 +: 5]; nv[0] = 1'b1;
                end else begin
                    na[0] = 5'd0; nv[0] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_addr[i] = na[i];
            x.m[i]    = nv[i] && (na[i] == query) && (query != 5'd0);
        end
        m_vld  = nv;
        x.addr = {na[2], na[1], na[0]};
        x.vld  = nv;
        sb.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    task automatic fill();
        step(0, 2'd1, 1, 0, 0);
        step(0, 2'd0, 1, 0, 0);
        step(0, 2'd2, 1, 0, 0);
        sb.delete();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
            e = sb.pop_front();
            tests++;
            if ({tap_addr, tap_valid, match, any_match} !== {e.addr, e.vld, e.m, |e.m}) begin
                fails++;
                $display("FAIL reset_sb cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                         tap_addr, tap_valid, match, any_match, e.addr, e.vld, e.m, |e.m);
            end
        end
        tests++;
        if ({tap_addr, tap_valid, match, any_match} !== 22'd0) begin
            fails++;
            $display("FAIL reset_zero: got %h/%b/%b/%b want all zero",
                     tap_addr, tap_valid, match, any_match);
        end
    endtask

    task automatic test_fill();
        step(0, 2'd1, 1, 0, 0);
        step(0, 2'd0, 1, 0, 0);
        step(0, 2'd2, 1, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (sb.size() == 0) begin
                tests++;
                if ({tap_addr, tap_valid} !== {e.addr, e.vld}) begin
                    fails++;
                    $display("FAIL fill_sb: got %h/%b want %h/%b", tap_addr, tap_valid, e.addr, e.vld);
                end
            end
        end
        tests++;
        if (tap_addr !== {5'd9, 5'd17, 5'd31} || tap_valid !== 3'b111) begin
            fails++;
            $display("FAIL fill_const: got %h/%b want %h/111", tap_addr, tap_valid,
                     {5'd9, 5'd17, 5'd31});
        end
    endtask

    task automatic test_bad_sel();
        fill();
        step(0, 2'd3, 1, 0, 0);
        e = sb.pop_front();
        tests++;
        if ({tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL bad_sel_sb: got %h/%b want %h/%b", tap_addr, tap_valid, e.addr, e.vld);
        end
        tests++;
        if (tap_addr !== {5'd17, 5'd31, 5'd0} || tap_valid !== 3'b110) begin
            fails++;
            $display("FAIL bad_sel_const: got %h/%b want %h/110", tap_addr, tap_valid,
                     {5'd17, 5'd31, 5'd0});
        end
    endtask

    task automatic test_stall();
        fill();
        for (int c = 0; c < 2; c++) begin
            step(0, 2'd1, 1, 1, 0);
            e = sb.pop_front();
            tests++;
            if (tap_addr !== {5'd9, 5'd17, 5'd31} || tap_valid !== 3'b111 ||
                {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
                fails++;
                $display("FAIL stall_hold cyc%0d: got %h/%b want %h/%b", c,
                         tap_addr, tap_valid, e.addr, e.vld);
            end
        end
        step(0, 2'd1, 1, 0, 0);
        e = sb.pop_front();
        tests++;
        if (tap_addr !== {5'd17, 5'd31, 5'd9} || {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL stall_release: got %h/%b want %h/%b", tap_addr, tap_valid, e.addr, e.vld);
        end
    endtask

    task automatic test_flush();
        fill();
        step(0, 2'd1, 1, 1, 1);
        e = sb.pop_front();
        tests++;
        if (tap_addr !== {5'd9, 5'd17, 5'd0} || tap_valid !== 3'b110 ||
            {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL flush_stall: got %h/%b want %h/110", tap_addr, tap_valid, e.addr);
        end
        fill();
        step(0, 2'd1, 1, 0, 1);
        e = sb.pop_front();
        tests++;
        if (tap_addr !== {5'd17, 5'd31, 5'd0} || tap_valid !== 3'b110 ||
            {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL flush_only: got %h/%b want %h/110", tap_addr, tap_valid, e.addr);
        end
    endtask

    task automatic test_match();
        fill();
        query = 5'd17;
        #1;
        tests++;
        if (match !== 3'b010 || any_match !== 1'b1) begin
            fails++;
            $display("FAIL match_17: got %b/%b want 010/1", match, any_match);
        end
        query = 5'd31;
        #1;
        tests++;
        if (match !== 3'b001 || any_match !== 1'b1) begin
            fails++;
            $display("FAIL match_31: got %b/%b want 001/1", match, any_match);
        end
        query = 5'd4;
        #1;
        tests++;
        if (match !== 3'b000 || any_match !== 1'b0) begin
            fails++;
            $display("FAIL match_none: got %b/%b want 000/0", match, any_match);
        end
        in_bus[4:0] = 5'd0;
        query       = 5'd0;
        step(0, 2'd0, 1, 0, 0);
        e = sb.pop_front();
        tests++;
        if ({tap_addr, tap_valid, match, any_match} !== {e.addr, e.vld, e.m, |e.m} ||
            tap_valid[0] !== 1'b1 || match !== 3'b000) begin
            fails++;
            $display("FAIL match_zero: got %h/%b/%b/%b want %h/%b/000/0", tap_addr, tap_valid,
                     match, any_match, e.addr, e.vld);
        end
        query = 5'd17;
        #1;
        tests++;
        if (match !== 3'b100 || any_match !== 1'b1) begin
            fails++;
            $display("FAIL match_17_s2: got %b/%b want 100/1", match, any_match);
        end
        in_bus[4:0] = 5'd17;
        query       = 5'd0;
    endtask

    task automatic test_mid_reset();
        fill();
        step(1, 2'd2, 1, 1, 0);
        e = sb.pop_front();
        tests++;
        if ({tap_addr, tap_valid, match, any_match} !== 22'd0 ||
            {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL mid_reset: got %h/%b/%b/%b want all zero", tap_addr, tap_valid,
                     match, any_match);
        end
        step(0, 2'd2, 1, 0, 0);
        e = sb.pop_front();
        tests++;
        if (tap_addr !== {5'd0, 5'd0, 5'd31} || tap_valid !== 3'b001 ||
            {tap_addr, tap_valid} !== {e.addr, e.vld}) begin
            fails++;
            $display("FAIL post_reset_entry: got %h/%b want %h/001", tap_addr, tap_valid, e.addr);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 20; c++) begin
            step(0, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));
            e = sb.pop_front();
            tests++;
            if ({tap_addr, tap_valid, match, any_match} !== {e.addr, e.vld, e.m, |e.m}) begin
                fails++;
                $display("FAIL random_sb cyc%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c,
                         tap_addr, tap_valid, match, any_match, e.addr, e.vld, e.m, |e.m);
            end
            if (c % 5 == 4) query = 5'($urandom_range(0, 1) ? 17 : 31);
        end
    endtask

    initial begin
        Rst = 1'b0; sel = 2'd0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        query  = 5'd0;
        in_bus = {5'd31, 5'd9, 5'd17};
        for (int i = 0; i < 3; i++) m_addr[i] = 5'd0;
        m_vld = 3'b000;
        test_reset();
        test_fill();
        test_bad_sel();
        test_stall();
        test_flush();
        test_match();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
